// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI mode-0 responder (spi_slave).
//   SPI_DATA_W_DEFAULT : default word width in bits
//   SPI_FILL_WORD      : word sent when the host has nothing ready (underrun)
//   spi_slave_state_t  : responder state (IDLE / ACTIVE)
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_DATA_W_DEFAULT = 8;
    localparam int SPI_FILL_WORD      = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slave_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchroniser for one asynchronous pin, followed by a one-cycle
// rise/fall detector working on the synchronised level.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   din    in   asynchronous pin
//   level  out  synchronised pin level
//   rise   out  one-cycle pulse on a synchronised 0->1 transition
//   fall   out  one-cycle pulse on a synchronised 1->0 transition
//
// Parameters:
//   SYNC_STAGES  synchroniser depth (2 or more)
//   RST_VAL      level the chain and edge history take during reset
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    // Fills with ones after reset. Edges are reported only once the chain and
    // the edge history hold real pin samples, so a pin that already differs
    // from RST_VAL when reset is released does not fake an edge. This keeps a
    // CS held low across a reset from restarting a transfer.
    logic [SYNC_STAGES:0]   prime_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg[0] <= RST_VAL;
        end else begin
            sync_reg[0] <= din;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= RST_VAL;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg  <= RST_VAL;
            prime_reg <= '0;
        end else begin
            prev_reg  <= sync_reg[SYNC_STAGES-1];
            prime_reg <= {prime_reg[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = prime_reg[SYNC_STAGES] &  level & ~prev_reg;
    assign fall  = prime_reg[SYNC_STAGES] & ~level &  prev_reg;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI mode-0 (CPOL=0, CPHA=0) responder. The SPI pins are oversampled in the
// clk_25mhz domain; MOSI is deserialised into DATA_W-bit words and a
// host-supplied word is shifted out on MISO, MSB first.
//
// Ports:
//   clk_25mhz    in   system clock
//   rst          in   synchronous active-high reset
//   spi_clk      in   SCLK from the master (asynchronous)
//   spi_cs       in   chip select, active low (asynchronous)
//   spi_mosi     in   master-out data (asynchronous)
//   spi_miso     out  slave-out data (registered, 0 when not selected)
//   rx_data      out  last complete received word
//   rx_valid     out  one-cycle strobe: rx_data updated
//   tx_data      in   next word to transmit
//   tx_valid     in   tx_data holds a fresh word
//   tx_ack       out  one-cycle strobe: tx_data consumed this cycle
//   tx_underrun  out  (only with SPI_SLAVE_UNDERRUN_EN) one-cycle pulse when a
//                     word load found tx_valid low and the fill word was sent
//   busy         out  high while the transfer is selected
//
// Build option: define SPI_SLAVE_UNDERRUN_EN to add the tx_underrun output.
// SCLK phases must each last at least 4 clk_25mhz cycles.
// -----------------------------------------------------------------------------
import spi_pkg::*;

module spi_slave #(
    parameter int DATA_W      = SPI_DATA_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_25mhz,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ack,
`ifdef SPI_SLAVE_UNDERRUN_EN
    output logic              tx_underrun,
`endif
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Synchronised pins and their edges
    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk   (clk_25mhz),
        .rst   (rst),
        .din   (spi_clk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk   (clk_25mhz),
        .rst   (rst),
        .din   (spi_cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk   (clk_25mhz),
        .rst   (rst),
        .din   (spi_mosi),
        .level (mosi_level),
        .rise  (),
        .fall  ()
    );

    spi_slave_state_t  state_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] rx_shift_reg;
    logic [DATA_W-1:0] tx_shift_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              rx_valid_reg;
    logic              tx_ack_reg;
    logic              spi_miso_reg;
`ifdef SPI_SLAVE_UNDERRUN_EN
    logic              tx_underrun_reg;
`endif

    // Transmit datapath: next shift-register contents and whether a new word
    // is taken from the host this cycle. cs_rise outranks any SCLK edge.
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] tx_shift_next;
    logic              load_req;
    logic              active_next;
    logic              word_done;

    assign word_done = (bit_cnt_reg == CNT_W'(DATA_W-1));

    always_comb begin
        load_word     = tx_valid ? tx_data : DATA_W'(SPI_FILL_WORD);
        load_req      = 1'b0;
        tx_shift_next = tx_shift_reg;
        active_next   = (state_reg == ACTIVE);
        if (state_reg == IDLE) begin
            if (cs_fall) begin
                tx_shift_next = load_word;
                load_req      = 1'b1;
                active_next   = 1'b1;
            end
        end else if (cs_rise) begin
            tx_shift_next = '0;
            active_next   = 1'b0;
        end else if (sclk_fall) begin
            // A counter at zero after a fall means the previous word has
            // just completed, so the next one is fetched instead of shifting.
            if (bit_cnt_reg == '0) begin
                tx_shift_next = load_word;
                load_req      = 1'b1;
            end else begin
                tx_shift_next = {tx_shift_reg[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            rx_shift_reg    <= '0;
            tx_shift_reg    <= '0;
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            tx_ack_reg      <= 1'b0;
            spi_miso_reg    <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
            tx_underrun_reg <= 1'b0;
`endif
        end else begin
            rx_valid_reg    <= 1'b0;
            tx_ack_reg      <= load_req & tx_valid;
`ifdef SPI_SLAVE_UNDERRUN_EN
            tx_underrun_reg <= load_req & ~tx_valid;
`endif
            tx_shift_reg    <= tx_shift_next;
            spi_miso_reg    <= active_next & tx_shift_next[DATA_W-1];

            case (state_reg)
                IDLE: begin
                    if (cs_fall) begin
                        state_reg   <= ACTIVE;
                        bit_cnt_reg <= '0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        // Any partial word is abandoned without a strobe.
                        state_reg   <= IDLE;
                        bit_cnt_reg <= '0;
                    end else if (sclk_rise) begin
                        rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], mosi_level};
                        if (word_done) begin
                            rx_data_reg  <= {rx_shift_reg[DATA_W-2:0], mosi_level};
                            rx_valid_reg <= 1'b1;
                            bit_cnt_reg  <= '0;
                        end else begin
                            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    bit_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign spi_miso = spi_miso_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign tx_ack   = tx_ack_reg;
    assign busy     = (state_reg == ACTIVE);
`ifdef SPI_SLAVE_UNDERRUN_EN
    assign tx_underrun = tx_underrun_reg;
`endif

    // The synchronised SCLK/CS levels are only consumed through their edges.
    logic unused_levels;
    assign unused_levels = sclk_level ^ cs_level;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Drives spi_slave as a mode-0 SPI master. Directed frames come from a vector
// table; random frames are checked against a frame-level model: every full
// MOSI word is received once, MISO word k is the k-th host word (or zero once
// the host runs dry), and the host is acked once per word load (frame start
// plus one per completed word) while it still has words.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_slave;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    logic              clk_25mhz = 1'b0;
    logic              rst       = 1'b1;
    logic              spi_clk   = 1'b0;
    logic              spi_cs    = 1'b1;
    logic              spi_mosi  = 1'b0;
    logic              spi_miso;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ack;
    logic              busy;
`ifdef SPI_SLAVE_UNDERRUN_EN
    logic              tx_underrun;
`endif

    spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_25mhz   (clk_25mhz),
        .rst         (rst),
        .spi_clk     (spi_clk),
        .spi_cs      (spi_cs),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ack      (tx_ack),
`ifdef SPI_SLAVE_UNDERRUN_EN
        .tx_underrun (tx_underrun),
`endif
        .busy        (busy)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int tests  = 0;
    int errors = 0;

    // Host side: a list of words offered in order, advancing on each tx_ack.
    logic [7:0] tx_words [4];
    int         tx_cnt   = 0;
    int         ack_base = 0;
    int         ack_cnt  = 0;
    int         tx_idx;
    assign tx_idx   = ack_cnt - ack_base;
    assign tx_valid = (tx_idx < tx_cnt);
    assign tx_data  = tx_valid ? tx_words[tx_idx[1:0]] : 8'h00;

    // Receive log, written only by the monitor.
    logic [7:0] rx_log [256];
    int         rx_cnt = 0;

    initial begin
        forever begin
            @(negedge clk_25mhz);
            if (rx_valid) begin
                rx_log[rx_cnt[7:0]] = rx_data;
                rx_cnt++;
            end
            if (tx_ack) ack_cnt++;
        end
    end

    // Master-side words for the current frame.
    logic [7:0] mosi_w [4];
    logic [7:0] miso_w [4];
    int         busy_bad;

    typedef struct {
        int         nw;
        logic [7:0] m0, m1;
        int         ntx;
        logic [7:0] t0, t1;
        int         last_bits;
        int         exp_nrx;
        logic [7:0] exp_rx0, exp_rx1;
        logic [7:0] exp_data;
        logic [7:0] exp_miso0, exp_miso1;
        int         exp_acks;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_25mhz);
    endtask

    // One SCLK period: present MOSI, sample MISO just before the rising edge.
    task automatic clock_bit(input logic b, input int half, output logic m);
        spi_mosi = b;
        wait_cyc(half);
        m = spi_miso;
        if (!busy) busy_bad++;
        spi_clk = 1'b1;
        wait_cyc(half);
        spi_clk = 1'b0;
    endtask

    task automatic frame(input int nw, input int last_bits, input int half);
        int   nb;
        logic m;
        busy_bad = 0;
        spi_cs = 1'b0;
        wait_cyc(half);
        for (int k = 0; k < nw; k++) begin
            miso_w[k] = 8'h00;
            nb = (k == nw - 1) ? last_bits : 8;
            for (int b = 0; b < nb; b++) begin
                clock_bit(mosi_w[k][7-b], half, m);
                miso_w[k][7-b] = m;
            end
        end
        wait_cyc(half);
        spi_cs = 1'b1;
        wait_cyc(SYNC_STAGES + 2);
        check("cs_rise_miso", {31'd0, spi_miso}, 32'd0);
        check("cs_rise_busy", {31'd0, busy}, 32'd0);
        wait_cyc(half);
    endtask

    task automatic set_host(input int n, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3);
        tx_words[0] = w0;
        tx_words[1] = w1;
        tx_words[2] = w2;
        tx_words[3] = w3;
        ack_base    = ack_cnt;
        tx_cnt      = n;
    endtask

    initial begin
        int         rx0;
        int         ack0;
        int         nw;
        int         ntx;
        int         half;
        int         exp_acks;
        logic       m;
        logic [7:0] exp_m;

        vecs[0] = '{1, 8'hA5, 8'h00, 1, 8'h3C, 8'h00, 8, 1, 8'hA5, 8'h00, 8'hA5, 8'h3C, 8'h00, 1};
        vecs[1] = '{2, 8'h12, 8'h34, 2, 8'h55, 8'hAA, 8, 2, 8'h12, 8'h34, 8'h34, 8'h55, 8'hAA, 2};
        vecs[2] = '{1, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8, 1, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 0};
        vecs[3] = '{1, 8'hC7, 8'h00, 1, 8'h99, 8'h00, 5, 0, 8'h00, 8'h00, 8'hFF, 8'h98, 8'h00, 1};
        vecs[4] = '{1, 8'h81, 8'h00, 0, 8'h00, 8'h00, 8, 1, 8'h81, 8'h00, 8'h81, 8'h00, 8'h00, 0};

        // Reset state
        set_host(0, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_cyc(5);
        check("rst_miso", {31'd0, spi_miso}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_ack", {31'd0, tx_ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_cyc(10);

        // Directed frames (1 MHz SCLK: 12-cycle half periods)
        for (int v = 0; v < 5; v++) begin
            set_host(vecs[v].ntx, vecs[v].t0, vecs[v].t1, 8'h00, 8'h00);
            mosi_w[0] = vecs[v].m0;
            mosi_w[1] = vecs[v].m1;
            rx0  = rx_cnt;
            ack0 = ack_cnt;
            frame(vecs[v].nw, vecs[v].last_bits, 12);
            wait_cyc(4);
            check("vec_rx_count", rx_cnt - rx0, vecs[v].exp_nrx);
            if (vecs[v].exp_nrx > 0) check("vec_rx0", {24'd0, rx_log[rx0[7:0]]}, {24'd0, vecs[v].exp_rx0});
            if (vecs[v].exp_nrx > 1) check("vec_rx1", {24'd0, rx_log[8'(rx0 + 1)]}, {24'd0, vecs[v].exp_rx1});
            check("vec_rx_data", {24'd0, rx_data}, {24'd0, vecs[v].exp_data});
            check("vec_miso0", {24'd0, miso_w[0]}, {24'd0, vecs[v].exp_miso0});
            if (vecs[v].nw > 1) check("vec_miso1", {24'd0, miso_w[1]}, {24'd0, vecs[v].exp_miso1});
            check("vec_acks", ack_cnt - ack0, vecs[v].exp_acks);
            check("vec_busy", busy_bad, 0);
            $display("[TB] vector %0d: mosi %02h/%02h rx %0d words, miso %02h/%02h, acks %0d",
                     v, vecs[v].m0, vecs[v].m1, rx_cnt - rx0, miso_w[0], miso_w[1], ack_cnt - ack0);
        end

        // Reset pulsed after bit 3 with CS held low: rest of the frame ignored.
        set_host(1, 8'hE7, 8'h00, 8'h00, 8'h00);
        rx0 = rx_cnt;
        busy_bad = 0;
        spi_cs = 1'b0;
        wait_cyc(12);
        for (int b = 0; b < 3; b++) clock_bit(1'b1, 12, m);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_miso", {31'd0, spi_miso}, 32'd0);
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_tx_ack", {31'd0, tx_ack}, 32'd0);
        exp_m = 8'h00;
        for (int b = 0; b < 5; b++) begin
            clock_bit(1'b1, 12, m);
            exp_m = {exp_m[6:0], m};
        end
        wait_cyc(12);
        spi_cs = 1'b1;
        wait_cyc(12);
        check("midrst_tail_miso", {24'd0, exp_m}, 32'd0);
        check("midrst_tail_rx", rx_cnt - rx0, 0);
        check("midrst_tail_busy", {31'd0, busy}, 32'd0);
        set_host(0, 8'h00, 8'h00, 8'h00, 8'h00);
        mosi_w[0] = 8'h5A;
        rx0 = rx_cnt;
        frame(1, 8, 12);
        wait_cyc(4);
        check("postrst_rx_count", rx_cnt - rx0, 1);
        check("postrst_rx", {24'd0, rx_data}, 32'h5A);
        $display("[TB] mid-frame reset: tail miso %02h, next frame rx %02h", exp_m, rx_data);

        // SCLK toggling with CS high: nothing happens.
        set_host(1, 8'hFF, 8'h00, 8'h00, 8'h00);
        rx0  = rx_cnt;
        ack0 = ack_cnt;
        exp_m = 8'h00;
        for (int b = 0; b < 16; b++) begin
            spi_mosi = 1'($urandom);
            wait_cyc(6);
            exp_m = exp_m | {7'd0, spi_miso};
            spi_clk = 1'b1;
            wait_cyc(6);
            spi_clk = 1'b0;
        end
        wait_cyc(8);
        check("idle_rx", rx_cnt - rx0, 0);
        check("idle_ack", ack_cnt - ack0, 0);
        check("idle_miso", {24'd0, exp_m}, 32'd0);
        $display("[TB] idle SCLK: rx %0d acks %0d", rx_cnt - rx0, ack_cnt - ack0);

        // Randomised frames against the frame-level model.
        for (int r = 0; r < 24; r++) begin
            nw   = int'($urandom_range(1, 3));
            ntx  = int'($urandom_range(0, 4));
            half = int'($urandom_range(4, 12));
            for (int k = 0; k < 4; k++) mosi_w[k] = 8'($urandom);
            set_host(ntx, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            rx0  = rx_cnt;
            ack0 = ack_cnt;
            frame(nw, 8, half);
            wait_cyc(4);
            exp_acks = (nw + 1 < ntx) ? nw + 1 : ntx;
            check("rand_rx_count", rx_cnt - rx0, nw);
            for (int k = 0; k < nw; k++) begin
                check("rand_rx", {24'd0, rx_log[8'(rx0 + k)]}, {24'd0, mosi_w[k]});
                exp_m = (k < ntx) ? tx_words[k] : 8'h00;
                check("rand_miso", {24'd0, miso_w[k]}, {24'd0, exp_m});
            end
            check("rand_acks", ack_cnt - ack0, exp_acks);
            check("rand_busy", busy_bad, 0);
            $display("[TB] random %0d: %0d words, host %0d, half %0d, acks %0d",
                     r, nw, ntx, half, ack_cnt - ack0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
